// File: rtl/seg_scan_ctrl_pkg.sv
// Shared display helpers for scanned seven-segment peripherals.
// Holds the nibble width, the digit-enable decoder and the leading-zero mask.
package seg_scan_ctrl_pkg;

    localparam int NIB_W      = 4;
    localparam int MAX_DIGITS = 8;
    localparam int MAX_VAL_W  = NIB_W * MAX_DIGITS;

    typedef logic [NIB_W-1:0] nibble_t;

    // Active-low one-hot enable for digit idx; callers truncate to their digit count.
    function automatic logic [MAX_DIGITS-1:0] an_onehot_n(input logic [2:0] idx);
        logic [MAX_DIGITS-1:0] one;
        one = MAX_DIGITS'(1);
        return ~(one << idx);
    endfunction

    // Bit i set when nibbles i..MAX_DIGITS-1 are all zero. Unused upper nibbles
    // are expected to be zero-extended by the caller.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [MAX_VAL_W-1:0] val);
        logic                  zero_above;
        logic [MAX_DIGITS-1:0] m;
        zero_above = 1'b1;
        m          = '0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above && (val[i*NIB_W +: NIB_W] == nibble_t'(0));
            m[i]       = zero_above;
        end
        return m;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_tick_gen.sv
// Free-running slot prescaler: counts 0..SCAN_DIV-1 and flags the last cycle.
// Shared by every scanned peripheral that needs a fixed slot rate.
module scan_tick_gen #(
    parameter int SCAN_DIV = 50000,
    parameter int CNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [CNT_W-1:0] cnt,
    output logic             tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    assign tick = (cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered loads,
// leading-zero blanking and per-slot dead-time. All outputs are registered.
module seg_scan_ctrl
    import seg_scan_ctrl_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GAP      = 2,
    parameter int BLANK_LZ = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load_i,
    input  logic [NIB_W*DIGITS-1:0] value_i,
    input  logic [DIGITS-1:0]       dp_i,
    output logic [NIB_W-1:0]        digit_o,
    output logic                    blank_o,
    output logic                    dp_o,
    output logic [DIGITS-1:0]       an_n,
    output logic                    load_ack,
    output logic                    frame_o
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = $clog2(DIGITS);
    localparam int VAL_W = NIB_W * DIGITS;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] GAP_C    = CNT_W'(GAP);

    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  tick;
    logic [IDX_W-1:0]      idx, idx_nxt;
    logic [VAL_W-1:0]      active_val, active_val_nxt, shadow_val;
    logic [DIGITS-1:0]     active_dp, active_dp_nxt, shadow_dp;
    logic                  pending;
    logic                  wrap, swap;
    logic [MAX_DIGITS-1:0] lz_all;
    logic [NIB_W-1:0]      digit_nxt;
    logic                  blank_nxt, dp_nxt;
    logic [DIGITS-1:0]     an_nxt;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV),
        .CNT_W    (CNT_W)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .cnt  (cnt),
        .tick (tick)
    );

    // Outputs are computed from next-cycle state so the flops present the
    // slot/k of the cycle they are visible in.
    always_comb begin
        wrap           = tick && (idx == LAST_IDX);
        swap           = wrap && pending;
        cnt_nxt        = tick ? '0 : cnt + CNT_W'(1);
        idx_nxt        = idx;
        if (tick) begin
            idx_nxt = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
        active_val_nxt = swap ? shadow_val : active_val;
        active_dp_nxt  = swap ? shadow_dp  : active_dp;
        lz_all         = lz_mask(MAX_VAL_W'(active_val_nxt));
        digit_nxt      = active_val_nxt[idx_nxt*NIB_W +: NIB_W];
        dp_nxt         = active_dp_nxt[idx_nxt];
        blank_nxt      = (BLANK_LZ != 0) && (idx_nxt != '0) && lz_all[3'(idx_nxt)];
        an_nxt         = (cnt_nxt < GAP_C) ? '1 : DIGITS'(an_onehot_n(3'(idx_nxt)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            active_val <= '0;
            active_dp  <= '0;
            shadow_val <= '0;
            shadow_dp  <= '0;
            pending    <= 1'b0;
            digit_o    <= '0;
            blank_o    <= 1'b0;
            dp_o       <= 1'b0;
            an_n       <= '1;
            load_ack   <= 1'b0;
            frame_o    <= 1'b0;
        end else begin
            idx        <= idx_nxt;
            active_val <= active_val_nxt;
            active_dp  <= active_dp_nxt;
            if (load_i) begin
                shadow_val <= value_i;
                shadow_dp  <= dp_i;
            end
            // A load on the wrap edge stays pending for the following frame.
            pending    <= load_i | (pending & ~wrap);
            digit_o    <= digit_nxt;
            blank_o    <= blank_nxt;
            dp_o       <= dp_nxt;
            an_n       <= an_nxt;
            load_ack   <= swap;
            frame_o    <= wrap;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DIGITS=4, SCAN_DIV=8, GAP=2, BLANK_LZ=1.
// Cycle 0 is the first cycle after reset release; samples are taken 1ns after posedge.
module tb_seg_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int GAP      = 2;
    localparam int BLANK_LZ = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_i = 1'b0;
    logic [15:0] value_i = '0;
    logic [3:0]  dp_i = '0;
    logic [3:0]  digit_o;
    logic        blank_o;
    logic        dp_o;
    logic [3:0]  an_n;
    logic        load_ack;
    logic        frame_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ack_cnt = 0;
    int frame_cnt = 0;

    seg_scan_ctrl #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .GAP      (GAP),
        .BLANK_LZ (BLANK_LZ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load_i   (load_i),
        .value_i  (value_i),
        .dp_i     (dp_i),
        .digit_o  (digit_o),
        .blank_o  (blank_o),
        .dp_o     (dp_o),
        .an_n     (an_n),
        .load_ack (load_ack),
        .frame_o  (frame_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=0x%0h expected=0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (load_ack === 1'b1) ack_cnt++;
        if (frame_o === 1'b1) frame_cnt++;
        chk("one_digit_max", 32'($countones(~an_n) <= 1), 32'd1);
    endtask

    task automatic goto(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_i = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
        ack_cnt = 0;
        frame_cnt = 0;
    endtask

    task automatic load(input int at, input logic [15:0] v, input logic [3:0] dp);
        goto(at);
        load_i = 1'b1;
        value_i = v;
        dp_i = dp;
        step();
        load_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and idle scan
        do_reset();
        chk("rst_an", an_n, 4'hF);
        chk("rst_digit", digit_o, 4'h0);
        chk("rst_blank", blank_o, 1'b0);
        chk("rst_frame", frame_o, 1'b0);
        chk("rst_ack", load_ack, 1'b0);
        goto(2);
        chk("c2_an", an_n, 4'hE);
        chk("c2_digit", digit_o, 4'h0);
        chk("c2_blank", blank_o, 1'b0);
        goto(8);
        chk("c8_an", an_n, 4'hF);
        goto(9);
        chk("c9_an", an_n, 4'hF);
        goto(10);
        chk("c10_an", an_n, 4'hD);
        chk("c10_blank", blank_o, 1'b1);
        goto(31);
        chk("no_frame_before_32", frame_cnt, 0);
        goto(32);
        chk("c32_frame", frame_o, 1'b1);
        chk("c32_no_ack", load_ack, 1'b0);

        // Load and blanking
        do_reset();
        load(3, 16'h0042, 4'b0001);
        goto(31);
        chk("ld_c31_digit", digit_o, 4'h0);
        chk("ld_c31_blank", blank_o, 1'b1);
        chk("ld_no_early_ack", ack_cnt, 0);
        goto(32);
        chk("ld_c32_ack", load_ack, 1'b1);
        chk("ld_c32_frame", frame_o, 1'b1);
        chk("ld_c32_digit", digit_o, 4'h2);
        chk("ld_c32_dp", dp_o, 1'b1);
        chk("ld_c32_blank", blank_o, 1'b0);
        goto(33);
        chk("ld_c33_ack", load_ack, 1'b0);
        goto(40);
        chk("ld_s1_digit", digit_o, 4'h4);
        chk("ld_s1_dp", dp_o, 1'b0);
        chk("ld_s1_blank", blank_o, 1'b0);
        goto(48);
        chk("ld_s2_blank", blank_o, 1'b1);
        goto(56);
        chk("ld_s3_blank", blank_o, 1'b1);

        // Latest load wins
        do_reset();
        load(5, 16'h1234, 4'b0000);
        load(20, 16'h9876, 4'b0000);
        goto(36);
        chk("lw_s0_digit", digit_o, 4'h6);
        goto(44);
        chk("lw_s1_digit", digit_o, 4'h7);
        goto(52);
        chk("lw_s2_digit", digit_o, 4'h8);
        chk("lw_s2_blank", blank_o, 1'b0);
        goto(60);
        chk("lw_s3_digit", digit_o, 4'h9);
        chk("lw_s3_blank", blank_o, 1'b0);
        goto(70);
        chk("lw_ack_count", ack_cnt, 1);

        // Load on the wrap edge
        do_reset();
        load(3, 16'h0001, 4'b0000);
        load(31, 16'h0FFF, 4'b0000);
        chk("we_c32_digit", digit_o, 4'h1);
        chk("we_c32_ack", load_ack, 1'b1);
        goto(40);
        chk("we_c40_blank", blank_o, 1'b1);
        goto(64);
        chk("we_c64_digit", digit_o, 4'hF);
        chk("we_c64_ack", load_ack, 1'b1);
        goto(80);
        chk("we_s2_digit", digit_o, 4'hF);
        chk("we_s2_blank", blank_o, 1'b0);
        goto(88);
        chk("we_s3_blank", blank_o, 1'b1);
        chk("we_s3_gap_an", an_n, 4'hF);
        goto(90);
        chk("we_s3_an", an_n, 4'h7);

        // Mid-frame reset discards pending load
        do_reset();
        load(3, 16'h5555, 4'b0000);
        goto(20);
        rst = 1'b1;
        goto(21);
        chk("mr_in_rst_an", an_n, 4'hF);
        goto(22);
        rst = 1'b0;
        cyc = 0;
        ack_cnt = 0;
        frame_cnt = 0;
        chk("mr_rel_an", an_n, 4'hF);
        chk("mr_rel_digit", digit_o, 4'h0);
        goto(34);
        chk("mr_c34_digit", digit_o, 4'h0);
        goto(42);
        chk("mr_c42_digit", digit_o, 4'h0);
        goto(40);
        chk("mr_no_ack", ack_cnt, 0);
        chk("mr_frame_count", frame_cnt, 1);

        // Embedded zeros under a nonzero top digit
        do_reset();
        load(3, 16'h1000, 4'b0000);
        goto(34);
        chk("ez_s0_digit", digit_o, 4'h0);
        chk("ez_s0_blank", blank_o, 1'b0);
        goto(42);
        chk("ez_s1_digit", digit_o, 4'h0);
        chk("ez_s1_blank", blank_o, 1'b0);
        goto(50);
        chk("ez_s2_digit", digit_o, 4'h0);
        chk("ez_s2_blank", blank_o, 1'b0);
        goto(58);
        chk("ez_s3_digit", digit_o, 4'h1);
        chk("ez_s3_blank", blank_o, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Multiplexed-display scan controller that feeds the shared hex-to-seven-segment decoder. It holds a DIGITS-nibble value, steps through one digit per scan slot, and presents that digit's nibble to the decoder with a one-hot, active-low digit enable. Loads are double-buffered so a new value is never shown half-updated. Leading-zero blanking and per-slot ghosting dead-time are built in.

## Interface
- DIGITS, 4: number of display digits (2..8).
- SCAN_DIV, 50000: clock cycles per digit slot (≥ GAP+2).
- GAP, 2: dead-time cycles at the start of each slot with all digits off.
- BLANK_LZ, 1: 1 enables leading-zero blanking.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load_i  in  1  single-cycle strobe; captures value_i/dp_i into the shadow register.
- value_i  in  4*DIGITS  nibble i = digit i; digit 0 is least significant.
- dp_i  in  DIGITS  decimal-point enable per digit.
- digit_o  out  4  nibble for the decoder's Din.
- blank_o  out  1  1 = suppress decoder segments this slot.
- dp_o  out  1  decimal point for the current digit.
- an_n  out  DIGITS  active-low one-hot digit enable.
- load_ack  out  1  one-cycle pulse when the shadow is committed to the display.
- frame_o  out  1  one-cycle pulse at the start of each frame.

## Operation
- State: prescaler cnt (0..SCAN_DIV-1), digit index idx (0..DIGITS-1), active value/dp, shadow value/dp, pending flag.
- Slot cycle k = cnt. A tick occurs when cnt = SCAN_DIV-1. On a tick, cnt goes to 0 and idx increments, wrapping from DIGITS-1 to 0.
- Frame wrap is the tick where idx wraps to 0. At frame wrap, if pending is set, active ← shadow and pending clears.
- load_i writes shadow and sets pending. A later load before the wrap overwrites shadow; the latest value wins.
- If load_i coincides with the wrap tick, the swap uses the shadow contents from before that edge. The new load becomes pending for the next frame.
- digit_o = active nibble[idx]; dp_o = active dp[idx].
- blank_o = BLANK_LZ && idx≠0 && active nibbles idx..DIGITS-1 are all zero. Digit 0 is never blanked. dp does not affect blanking.
- an_n = all ones for k < GAP. For k ≥ GAP, bit idx is 0 and all other bits are 1.
- Reset mid-frame returns all state to reset values immediately. Any pending load is discarded.

## Timing
- Reset values:
  - cnt=0, idx=0, active=0, shadow=0, pending=0.
  - digit_o=0, blank_o=0, dp_o=0, an_n=all ones, load_ack=0, frame_o=0.
- The first cycle after reset release is slot 0, k=0. Slot s occupies cycles s*SCAN_DIV .. s*SCAN_DIV+SCAN_DIV-1 of a frame.
- All outputs come from flops and are glitch-free. They are valid for the slot/k of the same cycle.
- digit_o, blank_o and dp_o change only on the first cycle of a slot. an_n is never active for two digits in the same cycle.
- load_ack and frame_o pulse on the first cycle of slot 0 following a wrap. load_ack only pulses when a swap occurred. Neither pulses out of reset.
- Load-to-display latency: up to one frame (DIGITS*SCAN_DIV cycles) plus 1 cycle.

## Structure
- Shared display package holds:
  - the one-hot active-low enable function (idx → an_n);
  - the leading-zero mask function;
  - the localparam types for nibble width (4).
- Sub-module scan_tick_gen(SCAN_DIV): free-running prescaler outputting cnt and a tick. It is reused by other scanned peripherals.
- Top-level scan logic: index counter, shadow/active registers, output flops.

## Test plan
Bench configuration: DIGITS=4, SCAN_DIV=8, GAP=2, BLANK_LZ=1. Cycle 0 is the first cycle after reset release.

- **Reset:** hold rst for 5 cycles, release. Cycles 0–1: an_n=1111. Cycle 2: an_n=1110, digit_o=0, blank_o=0. Cycles 8–9: an_n=1111. Cycle 10: an_n=1101, blank_o=1. frame_o stays 0 until cycle 32.
- **Load and blanking:** load_i at cycle 3 with value 0x0042, dp=0001. No change before cycle 32. At cycle 32: load_ack=1 and frame_o=1. Slot 0: digit_o=2, dp_o=1. Slot 1: digit_o=4. Slots 2–3: blank_o=1.
- **Latest load wins:** loads of 0x1234 at cycle 5 and 0x9876 at cycle 20. From cycle 32, slots 0–3 show 6,7,8,9 with blank_o=0. Exactly one load_ack pulse.
- **Load on the wrap edge:** load 0x0001 at cycle 3, load 0x0FFF at cycle 31.
  - Cycle 32: active=0x0001, load_ack=1.
  - Cycle 64: active=0x0FFF, load_ack=1, and slot 3 is blanked.
- **Mid-frame reset:** load 0x5555 at cycle 3, assert rst at cycle 20 for 2 cycles. After release: an_n=1111, active=0, and no load_ack at the next wrap.
- **Embedded zeros:** value 0x1000. Slots 1–2 show digit_o=0 with blank_o=0, because a higher nonzero digit exists.
